// File: rtl/alu_vec_driver.sv
// alu_vec_driver
//   Drives a fixed table of {code,a,b} vectors into a combinational 4-bit ALU.
//   Each vector is held for DELY cycles, then the ALU result is sampled and
//   compared against the expected value. The block counts mismatches and
//   records the index of the first failing vector.
//
// Parameters
//   DELY  settle cycles per vector (0 behaves as 1)
//   NVEC  number of table vectors run (1..6)
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start     run request, ignored while busy
//   c         5-bit ALU result
//   code,a,b  registered opcode/operands driven to the ALU
//   busy      run in progress
//   done      run finished (held until next start)
//   pass      valid with done, high when err_cnt == 0
//   err_cnt   saturating mismatch count
//   fail_idx  first failing vector index, 7 = none
//
// Build option
//   ALU_VEC_DRIVER_STOP_ON_FAIL_EN  end the run on the first mismatch
module alu_vec_driver #(
    parameter int DELY = 4,
    parameter int NVEC = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] c,
    output logic [1:0] code,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] fail_idx
);

    localparam int DLY = (DELY < 1) ? 1 : DELY;
    localparam int CW  = (DLY > 1) ? $clog2(DLY) : 1;
    localparam logic [2:0] LAST    = 3'(NVEC - 1);
    localparam logic [2:0] NO_FAIL = 3'd7;

    typedef struct packed {
        logic [1:0] code;
        logic [3:0] a;
        logic [3:0] b;
    } vec_t;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    function automatic vec_t vec_rom(input logic [2:0] i);
        case (i)
            3'd0:    vec_rom = '{2'd0, 4'b0000, 4'b1111};
            3'd1:    vec_rom = '{2'd0, 4'b0111, 4'b1101};
            3'd2:    vec_rom = '{2'd1, 4'b0001, 4'b0011};
            3'd3:    vec_rom = '{2'd2, 4'b1001, 4'b0011};
            3'd4:    vec_rom = '{2'd3, 4'b0011, 4'b0001};
            3'd5:    vec_rom = '{2'd3, 4'b0111, 4'b1001};
            default: vec_rom = '0;
        endcase
    endfunction

    function automatic logic [4:0] alu_exp(input logic [1:0] op, input logic [3:0] x,
                                           input logic [3:0] y);
        case (op)
            2'd0:    alu_exp = {1'b0, x} + {1'b0, y};
            2'd1:    alu_exp = {1'b0, x} - {1'b0, y};   // wraps mod 32
            2'd2:    alu_exp = {1'b0, x & y};
            default: alu_exp = {1'b0, x | y};
        endcase
    endfunction

    state_t        state;
    logic [2:0]    idx;
    logic [CW-1:0] dcnt;
    logic          mismatch;
    logic [3:0]    err_nxt;
    logic          finish;
    vec_t          vnext;

    assign mismatch = (c != alu_exp(code, a, b));
    assign vnext    = vec_rom(idx + 3'd1);

    // err_cnt as it will be after this SAMPLE; pass is derived from it so the
    // final mismatch of a run is already reflected when done rises.
    always_comb begin
        err_nxt = err_cnt;
        if (mismatch && err_cnt != 4'hf)
            err_nxt = err_cnt + 4'd1;
    end

`ifdef ALU_VEC_DRIVER_STOP_ON_FAIL_EN
    assign finish = (idx == LAST) || mismatch;
`else
    assign finish = (idx == LAST);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            dcnt     <= '0;
            code     <= '0;
            a        <= '0;
            b        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_idx <= NO_FAIL;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        err_cnt  <= '0;
                        fail_idx <= NO_FAIL;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        busy     <= 1'b1;
                        idx      <= '0;
                        {code, a, b} <= vec_rom(3'd0);
                        dcnt     <= CW'(DLY - 1);
                        state    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (dcnt == '0)
                        state <= SAMPLE;
                    else
                        dcnt <= dcnt - 1'b1;
                end
                SAMPLE: begin
                    err_cnt <= err_nxt;
                    if (mismatch && fail_idx == NO_FAIL)
                        fail_idx <= idx;
                    if (finish) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == 4'd0);
                        state <= DONE;
                    end else begin
                        idx          <= idx + 3'd1;
                        {code, a, b} <= vnext;
                        dcnt         <= CW'(DLY - 1);
                        state        <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_vec_driver.sv
// tb_alu_vec_driver
//   Randomized self-checking bench for alu_vec_driver. A behavioural ALU with
//   an injectable fault feeds c; the expected run outcome (length, driven
//   vector per cycle, err_cnt, fail_idx, pass) is predicted from the vector
//   table and the opcode arithmetic.
module tb_alu_vec_driver;

    localparam int DELY = 4;
    localparam int NVEC = 6;
    localparam int P    = ((DELY < 1) ? 1 : DELY) + 1;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [4:0] c;
    logic [1:0] code;
    logic [3:0] a, b, err_cnt;
    logic       busy, done, pass;
    logic [2:0] fail_idx;

    int         n_chk = 0, n_err = 0;
    int         fault_op = 4;          // 4 = healthy ALU
    logic       force0 = 1'b0;
    logic [4:0] xmask = 5'd0;
    logic [9:0] tbl [0:5];

    alu_vec_driver #(.DELY(DELY), .NVEC(NVEC)) dut (
        .clk(clk), .rst(rst), .start(start), .c(c),
        .code(code), .a(a), .b(b), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .fail_idx(fail_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ref_c(input logic [9:0] v);
        int op, x, y, r;
        op = int'(v[9:8]); x = int'(v[7:4]); y = int'(v[3:0]);
        case (op)
            0:       r = x + y;
            1:       r = (x - y + 32) % 32;
            2:       r = x & y;
            default: r = x | y;
        endcase
        return 5'(r);
    endfunction

    function automatic logic [4:0] alu_out(input logic [9:0] v);
        logic [4:0] r;
        r = ref_c(v);
        if (int'(v[9:8]) == fault_op) r = force0 ? 5'd0 : (r ^ xmask);
        return r;
    endfunction

    always_comb begin
        c = 5'd0;
        c = alu_out({code, a, b});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge. rp = edge (relative to the start edge) at which
    // start is pulsed again while busy; 0 = no re-pulse.
    task automatic do_run(input int rp);
        int first, errs, nexp, lastv;
        first = -1; errs = 0;
        for (int i = 0; i < NVEC; i++)
            if (alu_out(tbl[i]) != ref_c(tbl[i])) begin
                errs++;
                if (first < 0) first = i;
            end
`ifdef ALU_VEC_DRIVER_STOP_ON_FAIL_EN
        if (first >= 0) begin
            nexp = (first + 1) * P; lastv = first; errs = 1;
        end else begin
            nexp = NVEC * P; lastv = NVEC - 1;
        end
`else
        nexp = NVEC * P; lastv = NVEC - 1;
        if (errs > 15) errs = 15;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= nexp; k++) begin
            if (k == 0)
                chk("clr", 32'({err_cnt, fail_idx}), 32'({4'd0, 3'd7}));
            if (k < nexp) begin
                chk("run", 32'({busy, done, pass, code, a, b}),
                    32'({3'b100, tbl[k / P]}));
                start = (rp > 0 && rp < nexp && k + 1 == rp);
                @(negedge clk);
            end else begin
                chk("end", 32'({busy, done, code, a, b}), 32'({2'b01, tbl[lastv]}));
                chk("pass", 32'(pass), 32'(errs == 0));
                chk("err_cnt", 32'(err_cnt), 32'(errs));
                chk("fail_idx", 32'(fail_idx), (first < 0) ? 32'd7 : 32'(first));
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("hold", 32'({busy, done, pass, err_cnt, fail_idx, code, a, b}),
            32'({2'b01, errs == 0, 4'(errs), (first < 0) ? 3'd7 : 3'(first), tbl[lastv]}));
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, 32'({busy, done, pass, code, a, b, err_cnt, fail_idx}), 32'({23'd0, 3'd7}));
    endtask

    initial begin
        tbl[0] = {2'd0, 4'b0000, 4'b1111};
        tbl[1] = {2'd0, 4'b0111, 4'b1101};
        tbl[2] = {2'd1, 4'b0001, 4'b0011};
        tbl[3] = {2'd2, 4'b1001, 4'b0011};
        tbl[4] = {2'd3, 4'b0011, 4'b0001};
        tbl[5] = {2'd3, 4'b0111, 4'b1001};
        rst = 1'b0; start = 1'b0;
        #1 rst = 1'b1;
        #2 chk_idle("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("idle_after_rst");

        // healthy ALU, then opcode-1 stuck at zero, then healthy restart from DONE
        fault_op = 4; do_run(0);
        fault_op = 1; force0 = 1'b1; do_run(0);
        fault_op = 4; force0 = 1'b0; do_run(10);

        // reset during DRIVE of vector 3
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_idle("rst_midrun");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("idle_after_abort");
        do_run(0);

        for (int t = 0; t < 10; t++) begin
            fault_op = $urandom_range(0, 4);
            force0   = 1'($urandom_range(0, 1));
            xmask    = 5'($urandom_range(1, 31));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_run($urandom_range(0, 29));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
